// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps a 2-input gate under test through all input vectors and counts mismatches.
// Optional GTC_FIRST_FAIL_EN adds fail_vec/fail_vld capturing the first failing vector of a sweep.
module gate_truth_checker #(
  parameter int SETTLE = 1,
  parameter int REPEAT = 1,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GTC_FIRST_FAIL_EN
  ,
  output logic [1:0]       fail_vec,
  output logic             fail_vld
`endif
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;
  // With no settle time a vector goes straight to its check cycle
  localparam state_t VEC_ST = (SETTLE == 0) ? CHECK : DRIVE;
  localparam logic [3:0] SET_M1 = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_t state, nxt;
  logic [3:0] cnt, sweeps;
  logic [2:0] op_q;
  logic exp_y, mis, accept, bad_op, last_vec;
  assign accept   = state == IDLE && start && op <= 3'd5;
  assign bad_op   = state == IDLE && start && op >= 3'd6;
  assign last_vec = {a, b} == 2'b11;
  assign mis      = state == CHECK && y != exp_y;
  always_comb begin
    exp_y = op_q == 3'd0 ? a & b :
            op_q == 3'd1 ? a | b :
            op_q == 3'd2 ? ~(a & b) :
            op_q == 3'd3 ? ~(a | b) :
            op_q == 3'd4 ? a ^ b : ~(a ^ b);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? VEC_ST : IDLE;
      DRIVE:   nxt = cnt == 4'd0 ? CHECK : DRIVE;
      CHECK:   nxt = (last_vec && sweeps == 4'd1) ? FIN : VEC_ST;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a, b}  <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      cnt     <= '0;
      sweeps  <= '0;
      op_q    <= '0;
`ifdef GTC_FIRST_FAIL_EN
      fail_vec <= 2'b00;
      fail_vld <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q    <= op;
        err_cnt <= '0;
        pass    <= 1'b0;
        {a, b}  <= 2'b00;
        busy    <= 1'b1;
        cnt     <= SET_M1;
        sweeps  <= 4'(REPEAT);
`ifdef GTC_FIRST_FAIL_EN
        fail_vec <= 2'b00;
        fail_vld <= 1'b0;
`endif
      end else if (bad_op) begin
        done    <= 1'b1;
        pass    <= 1'b0;
        err_cnt <= '0;
      end else if (state == DRIVE) begin
        cnt <= cnt - 4'd1;
      end else if (state == CHECK) begin
        {a, b} <= {a, b} + 2'd1;
        cnt    <= SET_M1;
        if (last_vec) sweeps <= sweeps - 4'd1;
        if (mis && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
`ifdef GTC_FIRST_FAIL_EN
        if (mis && !fail_vld) begin
          fail_vec <= {a, b};
          fail_vld <= 1'b1;
        end
`endif
      end else if (state == FIN) begin
        done   <= 1'b1;
        busy   <= 1'b0;
        pass   <= err_cnt == '0;
        {a, b} <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: directed checks of gate_truth_checker with a behavioural gate under test.
module tb_gate_truth_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, y, a, b, busy, done, pass;
  logic [2:0] op = 3'd0;
  logic [3:0] err_cnt;
  logic start2 = 1'b0, y2, a2, b2, busy2, done2, pass2;
  logic [2:0] op2 = 3'd1;
  logic [1:0] err2;
  logic [1:0] gut = 2'd0;
  int checks = 0, errors = 0;
`ifdef GTC_FIRST_FAIL_EN
  logic [1:0] fv, fv2;
  logic fl, fl2;
`endif
  always #5 clk = ~clk;
  // gut: 0 NAND, 1 AND, otherwise stuck-at-0
  assign y  = gut == 2'd0 ? ~(a & b) : gut == 2'd1 ? (a & b) : 1'b0;
  assign y2 = 1'b0;
  gate_truth_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef GTC_FIRST_FAIL_EN
    , .fail_vec(fv), .fail_vld(fl)
`endif
  );
  gate_truth_checker #(.SETTLE(1), .REPEAT(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .y(y2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GTC_FIRST_FAIL_EN
    , .fail_vec(fv2), .fail_vld(fl2)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic [2:0] o);
    op = o;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
  endtask
  task automatic test_reset();
    step();
    step();
    checks++;
    if ({a, b, busy, done, pass, err_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset outs got %b exp 0", {a, b, busy, done, pass, err_cnt});
    end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_nand_sweep();
    gut = 2'd0;
    pulse_start(3'd2);
    for (int n = 0; n < 8; n++) begin
      checks++;
      if ({a, b, busy, done} !== {2'(n / 2), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL nand_vec n=%0d got %b exp %b", n, {a, b, busy, done}, {2'(n / 2), 2'b10});
      end
      step();
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL nand_early_done got %b exp 0", done);
    end
    step();
    checks++;
    if ({done, busy, pass, err_cnt, a, b} !== {3'b101, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL nand_done got %b exp 101000000", {done, busy, pass, err_cnt, a, b});
    end
    step();
    checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL nand_pulse done=%b pass=%b exp done=0 pass=1", done, pass);
    end
  endtask
  task automatic test_wrong_gut();
    int n;
    gut = 2'd1;
    pulse_start(3'd2);
    wait_done(n);
    checks++;
    if (n !== 9 || err_cnt !== 4'd4 || pass !== 1'b0) begin
      errors++;
      $display("FAIL and_gut n=%0d err=%0d pass=%b exp n=9 err=4 pass=0", n, err_cnt, pass);
    end
`ifdef GTC_FIRST_FAIL_EN
    checks++;
    if (fv !== 2'b00 || fl !== 1'b1) begin
      errors++;
      $display("FAIL first_fail vec=%b vld=%b exp 00 1", fv, fl);
    end
`endif
    step();
  endtask
  task automatic test_saturate();
    int n = 0;
    op2 = 3'd1;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    while (!done2 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 17 || err2 !== 2'd3 || pass2 !== 1'b0) begin
      errors++;
      $display("FAIL saturate n=%0d err=%0d pass=%b exp n=17 err=3 pass=0", n, err2, pass2);
    end
    step();
  endtask
  task automatic test_illegal_op();
    pulse_start(3'd7);
    checks++;
    if ({done, busy, pass, err_cnt} !== 7'b1000000) begin
      errors++;
      $display("FAIL illegal_done got %b exp 1000000", {done, busy, pass, err_cnt});
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after done=%b busy=%b exp 0 0", done, busy);
    end
  endtask
  task automatic test_reset_abort();
    int n, seen = 0;
    gut = 2'd0;
    pulse_start(3'd2);
    repeat (4) step();
    checks++;
    if ({a, b, busy} !== 3'b101) begin
      errors++;
      $display("FAIL abort_vec got %b exp 101", {a, b, busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, busy, done, pass, err_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL abort_outs got %b exp 0", {a, b, busy, done, pass, err_cnt});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      step();
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone done_seen=%0d busy=%b exp 0 0", seen, busy);
    end
    pulse_start(3'd2);
    wait_done(n);
    checks++;
    if (n !== 9 || pass !== 1'b1 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_restart n=%0d pass=%b err=%0d exp 9 1 0", n, pass, err_cnt);
    end
    step();
  endtask
  task automatic test_back_to_back();
    int n;
    gut = 2'd0;
    op = 3'd2;
    start = 1'b1;
    step();
    op = 3'd4;
    wait_done(n);
    checks++;
    if (n !== 9 || pass !== 1'b1 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL b2b_first n=%0d pass=%b err=%0d exp 9 1 0", n, pass, err_cnt);
    end
    step();
    checks++;
    if ({busy, done, a, b} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_rearm got %b exp 1000", {busy, done, a, b});
    end
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 9 || pass !== 1'b0 || err_cnt !== 4'd1) begin
      errors++;
      $display("FAIL b2b_xor n=%0d pass=%b err=%0d exp 9 0 1", n, pass, err_cnt);
    end
`ifdef GTC_FIRST_FAIL_EN
    checks++;
    if (fv !== 2'b00 || fl !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_fail vec=%b vld=%b exp 00 1", fv, fl);
    end
`endif
    step();
  endtask
  initial begin
    test_reset();
    test_nand_sweep();
    test_wrong_gut();
    test_saturate();
    test_illegal_op();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
